// File: rtl/cs_series_filter_if.sv
// Sample/result bundle for cs_series_filter: 8-bit sample stream in, 10-bit filtered result out.
interface cs_series_filter_if;
  logic [7:0] X;
  logic [9:0] Y;

  modport master (output X, input Y);
  modport slave  (input X, output Y);
endinterface

// File: rtl/cs_series_filter.sv
// Nine-tap sliding-window approximate-average filter:
// Y = floor((sum + 9 * largest sample not above the window average) / 8).
module cs_series_filter (
  input  logic               clk,
  input  logic               reset,
  cs_series_filter_if.slave  bus
);

  localparam int unsigned DEPTH = 9;

  logic [7:0]  r_win [DEPTH];
  logic [11:0] w_sum;
  logic [7:0]  w_xappr;
  logic [12:0] w_total;

  always_ff @(posedge clk) begin
    // NOTE: the window is real state whose cleared value is observable on Y, so it is reset; a storage array with no reset meaning would be left unreset.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every tap take its neighbour's pre-edge value, giving a true shift.
      r_win[0] <= bus.X;
      for (int i = 1; i < DEPTH; i++) r_win[i] <= r_win[i-1];
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_sum   = '0;
    w_xappr = '0;
    for (int i = 0; i < DEPTH; i++) w_sum = w_sum + 12'(r_win[i]);
    // Comparing 9*Wi against the sum avoids a divide-by-9; the minimum always qualifies.
    for (int i = 0; i < DEPTH; i++) begin
      if ((12'd9 * {4'd0, r_win[i]}) <= w_sum && r_win[i] > w_xappr)
        w_xappr = r_win[i];
    end
  end

  assign w_total = {1'b0, w_sum} + 13'd9 * {5'd0, w_xappr};
  assign bus.Y   = 10'(w_total >> 3);

endmodule

// File: tb/tb_cs_series_filter.sv
// Directed and random checks of cs_series_filter against hand-computed values and a window model.
module tb_cs_series_filter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_win [9];

  cs_series_filter_if bus ();

  cs_series_filter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] exp);
    n_checks++;
    assert (bus.Y === exp) n_pass++;
    else $error("FAIL %s: Y=0x%03h expected 0x%03h", tag, bus.Y, exp);
  endtask

  // Drive one sample, clock it in, and settle past the edge before any check.
  task automatic push(input logic [7:0] v);
    bus.X = v;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 9; i++) m_win[i] = 0;
    end else begin
      for (int i = 8; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = int'(v);
    end
  endtask

  // Reference result computed with a true integer average.
  function automatic logic [9:0] model();
    int s = 0;
    int a = 0;
    for (int i = 0; i < 9; i++) s += m_win[i];
    for (int i = 0; i < 9; i++) if (m_win[i] <= s / 9 && m_win[i] > a) a = m_win[i];
    return 10'((s + 9 * a) / 8);
  endfunction

  initial begin
    reset = 1'b1;
    bus.X = 8'hAB;
    for (int i = 0; i < 9; i++) m_win[i] = 0;

    push(8'hAB); check("reset_edge1", 10'h000);
    push(8'hAB); check("reset_edge2", 10'h000);
    reset = 1'b0;

    // k samples of 0x10 with zeros elsewhere: only zero qualifies until the window fills.
    for (int k = 1; k <= 8; k++) begin
      push(8'h10);
      check($sformatf("fill_%0d", k), 10'(2 * k));
    end
    push(8'h10); check("const_10", 10'h024);

    push(8'hFF); check("ff_first", 10'h041);
    for (int k = 2; k <= 9; k++) push(8'hFF);
    check("const_ff_max", 10'h23D);

    for (int k = 1; k <= 9; k++) push(8'(k));
    check("ramp_1_9", 10'h00B);
    push(8'd10); check("ramp_2_10", 10'h00D);

    for (int k = 0; k < 8; k++) push(8'd0);
    push(8'hFF); check("outlier_new", 10'h01F);
    for (int k = 0; k < 8; k++) push(8'd0);
    check("outlier_oldest", 10'h01F);
    push(8'd0); check("outlier_evicted", 10'h000);

    push(8'd12);
    for (int k = 0; k < 8; k++) push(8'd3);
    check("eq_reject_12", 10'h007);
    for (int k = 0; k < 9; k++) push(8'd4);
    check("eq_accept_4", 10'h009);

    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        reset = 1'b1;
        push(8'($urandom_range(0, 255)));
        check("mid_reset", 10'h000);
        reset = 1'b0;
      end
      push(8'($urandom_range(0, 255)));
      check($sformatf("rand_%0d", n), model());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
